// File: rtl/host_cmd_rx.sv
// host_cmd_rx
//   Host-side command receiver. A 3-wire serial link (sclk, sdata, cs_n) that is
//   asynchronous to clk is synchronised, deserialised and turned into register
//   write strobes.
//
//   Frame: one address byte, then one or more DATA_W-bit words, all MSB first.
//   The address auto-increments (mod 2^ADDR_W) after every completed word.
//
//   Ports
//     clk          system clock
//     rst          synchronous active-high reset
//     sclk_pin     serial clock from host (async)
//     sdata_pin    serial data, changes only while sclk is low (async)
//     csn_pin      frame select, active low (async)
//     wr_en        one-cycle write strobe; wr_addr/wr_data are valid with it
//                  and held until the next strobe
//     wr_addr      write address
//     wr_data      write data
//     frame_err    one-cycle pulse when a frame closes on a partial byte/word
//     busy         high while a frame is open
//     dbg_state_o  current FSM state (IDLE=0, ADDR=1, DATA=2)
//
//   Output protocol: wr_en and frame_err are plain strobes with no back
//   pressure; a consumer must accept a write in the cycle wr_en is high.
module host_cmd_rx #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk_pin,
   input  logic              sdata_pin,
   input  logic              csn_pin,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              frame_err,
   output logic              busy,
   output logic [1:0]        dbg_state_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   localparam int         NB      = DATA_W / 8;
   localparam logic [2:0] NB_LAST = 3'(NB - 1);

   // Synchroniser chains: [0]=s1, [1]=s2, [2]=s3 (history, edge detect only).
   logic [2:0] sclk_sync_q;
   logic [2:0] csn_sync_q;
   logic [1:0] sdata_sync_q;

   // After reset the csn chain is forced high, so a pin held low through reset
   // would look like a fall. Frames are only accepted once the synchronised
   // pin has genuinely been seen high after reset.
   logic [1:0] settle_q;
   logic       armed_q;

   logic [1:0]        state_q,     state_d;
   logic [2:0]        bit_cnt_q,   bit_cnt_d;
   logic [2:0]        byte_cnt_q,  byte_cnt_d;
   logic [DATA_W-2:0] sh_q,        sh_d;
   logic [ADDR_W-1:0] addr_q,      addr_d;
   logic              wr_en_q,     wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
   logic [DATA_W-1:0] wr_data_q,   wr_data_d;
   logic              frame_err_q, frame_err_d;

   logic              sclk_rise;
   logic              csn_rise;
   logic              csn_fall;
   logic [DATA_W-1:0] sh_shift;

   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign csn_rise  = csn_sync_q[1]  & ~csn_sync_q[2];
   assign csn_fall  = ~csn_sync_q[1] &  csn_sync_q[2];
   assign sh_shift  = {sh_q, sdata_sync_q[1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_q  <= 3'b000;
         csn_sync_q   <= 3'b111;
         sdata_sync_q <= 2'b00;
         settle_q     <= 2'd0;
         armed_q      <= 1'b0;
      end else begin
         sclk_sync_q  <= {sclk_sync_q[1:0], sclk_pin};
         csn_sync_q   <= {csn_sync_q[1:0], csn_pin};
         sdata_sync_q <= {sdata_sync_q[0], sdata_pin};
         // settle_q==2 means s2 now holds a pin sample taken after reset.
         if (settle_q != 2'd2) begin
            settle_q <= settle_q + 2'd1;
         end
         if ((settle_q == 2'd2) && csn_sync_q[1]) begin
            armed_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      sh_d        = sh_q;
      addr_d      = addr_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      frame_err_d = 1'b0;

      if (csn_rise) begin
         // Frame close takes priority over a coincident sclk rise: that bit is
         // dropped and the check uses the counters as they were before it.
         if ((state_q != ST_IDLE) && ((bit_cnt_q != 3'd0) || (byte_cnt_q != 3'd0))) begin
            frame_err_d = 1'b1;
         end
         state_d    = ST_IDLE;
         bit_cnt_d  = 3'd0;
         byte_cnt_d = 3'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (csn_fall && armed_q) begin
                  state_d    = ST_ADDR;
                  bit_cnt_d  = 3'd0;
                  byte_cnt_d = 3'd0;
               end
            end
            ST_ADDR: begin
               if (sclk_rise) begin
                  sh_d = sh_shift[DATA_W-2:0];
                  if (bit_cnt_q == 3'd7) begin
                     addr_d     = sh_shift[ADDR_W-1:0];
                     state_d    = ST_DATA;
                     bit_cnt_d  = 3'd0;
                     byte_cnt_d = 3'd0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end
            end
            ST_DATA: begin
               if (sclk_rise) begin
                  sh_d = sh_shift[DATA_W-2:0];
                  if (bit_cnt_q == 3'd7) begin
                     bit_cnt_d = 3'd0;
                     if (byte_cnt_q == NB_LAST) begin
                        // Exactly DATA_W bits have been shifted since the
                        // address byte, so sh_shift holds the whole word.
                        wr_en_d    = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = sh_shift;
                        addr_d     = addr_q + ADDR_W'(1);
                        byte_cnt_d = 3'd0;
                     end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         byte_cnt_q  <= 3'd0;
         sh_q        <= '0;
         addr_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         sh_q        <= sh_d;
         addr_q      <= addr_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign frame_err   = frame_err_q;
   assign busy        = (state_q != ST_IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_host_cmd_rx.sv
// tb_host_cmd_rx
//   Directed bench for host_cmd_rx. Two instances share one host driver: a
//   DATA_W=16 instance (default) and a DATA_W=32 instance selected by sel32;
//   the unselected instance sees an idle link. Expected writes are queued as
//   frames are driven and popped by a monitor when wr_en fires.
module tb_host_cmd_rx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sclk = 1'b0;
   logic sdata = 1'b0;
   logic csn = 1'b1;
   logic sel32 = 1'b0;

   logic        sclk16, csn16, sclk32, csn32;
   logic        wr_en16, frame_err16, busy16;
   logic [7:0]  wr_addr16;
   logic [15:0] wr_data16;
   logic [1:0]  state16;
   logic        wr_en32, frame_err32, busy32;
   logic [7:0]  wr_addr32;
   logic [31:0] wr_data32;
   logic [1:0]  state32;

   assign sclk16 = sel32 ? 1'b0 : sclk;
   assign csn16  = sel32 ? 1'b1 : csn;
   assign sclk32 = sel32 ? sclk : 1'b0;
   assign csn32  = sel32 ? csn  : 1'b1;

   host_cmd_rx #(.ADDR_W(8), .DATA_W(16)) u16 (
      .clk(clk), .rst(rst), .sclk_pin(sclk16), .sdata_pin(sdata), .csn_pin(csn16),
      .wr_en(wr_en16), .wr_addr(wr_addr16), .wr_data(wr_data16),
      .frame_err(frame_err16), .busy(busy16), .dbg_state_o(state16)
   );

   host_cmd_rx #(.ADDR_W(8), .DATA_W(32)) u32 (
      .clk(clk), .rst(rst), .sclk_pin(sclk32), .sdata_pin(sdata), .csn_pin(csn32),
      .wr_en(wr_en32), .wr_addr(wr_addr32), .wr_data(wr_data32),
      .frame_err(frame_err32), .busy(busy32), .dbg_state_o(state32)
   );

   // ---------------- clock / reset bookkeeping ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   logic [39:0] exp16_q[$];
   logic [39:0] exp32_q[$];
   int n_pass = 0;
   int n_total = 0;
   int wr16_cnt = 0, err16_cnt = 0, wr32_cnt = 0, err32_cnt = 0;
   int last_wr16_cyc = 0;
   int rise_cyc = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      logic [39:0] e;
      if (!rst) begin
         if (wr_en16 | frame_err16) check("excl16", {63'd0, wr_en16 & frame_err16}, 64'd0);
         if (wr_en32 | frame_err32) check("excl32", {63'd0, wr_en32 & frame_err32}, 64'd0);
         if (frame_err16) err16_cnt++;
         if (frame_err32) err32_cnt++;
         if (wr_en16) begin
            wr16_cnt++;
            last_wr16_cyc = cyc;
            check("wr16_expected", {63'd0, exp16_q.size() != 0}, 64'd1);
            if (exp16_q.size() != 0) begin
               e = exp16_q.pop_front();
               check("wr16_addr", {56'd0, wr_addr16}, {56'd0, e[39:32]});
               check("wr16_data", {48'd0, wr_data16}, {32'd0, e[31:0]});
            end
         end
         if (wr_en32) begin
            wr32_cnt++;
            check("wr32_expected", {63'd0, exp32_q.size() != 0}, 64'd1);
            if (exp32_q.size() != 0) begin
               e = exp32_q.pop_front();
               check("wr32_addr", {56'd0, wr_addr32}, {56'd0, e[39:32]});
               check("wr32_data", {32'd0, wr_data32}, {32'd0, e[31:0]});
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [31:0] v, input int n, input int h);
      for (int i = n - 1; i >= 0; i--) begin
         sdata = v[i];
         tick(h);
         sclk = 1'b1;
         rise_cyc = cyc;
         tick(h);
         sclk = 1'b0;
      end
   endtask

   task automatic csn_start();
      csn = 1'b0;
      tick(4);
   endtask

   task automatic csn_end();
      tick(4);
      csn = 1'b1;
      tick(8);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int w0, e0, k;

      tick(4);
      check("rst_wr_en", {63'd0, wr_en16}, 64'd0);
      check("rst_frame_err", {63'd0, frame_err16}, 64'd0);
      check("rst_busy", {63'd0, busy16}, 64'd0);
      check("rst_wr_addr", {56'd0, wr_addr16}, 64'd0);
      check("rst_wr_data", {48'd0, wr_data16}, 64'd0);
      check("rst_state32", {62'd0, state32}, 64'd0);
      rst = 1'b0;
      tick(6);

      // 1: single word, latency and busy
      w0 = wr16_cnt; e0 = err16_cnt;
      exp16_q.push_back({8'h12, 32'h0000BEEF});
      csn_start();
      check("t1_busy_open", {63'd0, busy16}, 64'd1);
      send_bits(32'h12, 8, 4);
      check("t1_state_data", {62'd0, state16}, 64'd2);
      send_bits(32'hBEEF, 16, 4);
      k = rise_cyc;
      csn_end();
      check("t1_latency", 64'(last_wr16_cyc - k), 64'd3);
      check("t1_wr_cnt", 64'(wr16_cnt - w0), 64'd1);
      check("t1_err_cnt", 64'(err16_cnt - e0), 64'd0);
      check("t1_busy_closed", {63'd0, busy16}, 64'd0);

      // 2: burst with address wrap
      w0 = wr16_cnt; e0 = err16_cnt;
      exp16_q.push_back({8'hFE, 32'h0001});
      exp16_q.push_back({8'hFF, 32'h0002});
      exp16_q.push_back({8'h00, 32'h0003});
      csn_start();
      send_bits(32'hFE, 8, 4);
      send_bits(32'h0001, 16, 4);
      send_bits(32'h0002, 16, 4);
      send_bits(32'h0003, 16, 4);
      csn_end();
      check("t2_wr_cnt", 64'(wr16_cnt - w0), 64'd3);
      check("t2_err_cnt", 64'(err16_cnt - e0), 64'd0);

      // 3: truncated word, then a good frame
      w0 = wr16_cnt; e0 = err16_cnt;
      csn_start();
      send_bits(32'h05, 8, 4);
      send_bits(32'h5A5, 11, 4);
      csn_end();
      check("t3_trunc_wr", 64'(wr16_cnt - w0), 64'd0);
      check("t3_trunc_err", 64'(err16_cnt - e0), 64'd1);
      w0 = wr16_cnt; e0 = err16_cnt;
      exp16_q.push_back({8'h06, 32'h1234});
      csn_start();
      send_bits(32'h06, 8, 4);
      send_bits(32'h1234, 16, 4);
      csn_end();
      check("t3_good_wr", 64'(wr16_cnt - w0), 64'd1);
      check("t3_good_err", 64'(err16_cnt - e0), 64'd0);

      // 4: address-only frame and empty frame
      w0 = wr16_cnt; e0 = err16_cnt;
      csn_start();
      send_bits(32'h33, 8, 4);
      csn_end();
      csn = 1'b0;
      tick(10);
      csn = 1'b1;
      tick(8);
      check("t4_wr", 64'(wr16_cnt - w0), 64'd0);
      check("t4_err", 64'(err16_cnt - e0), 64'd0);

      // 5: reset mid-frame with csn held low through release
      w0 = wr16_cnt; e0 = err16_cnt;
      csn_start();
      send_bits(32'h40, 8, 4);
      send_bits(32'hABC, 12, 4);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(4);
      check("t5_busy_after_rst", {63'd0, busy16}, 64'd0);
      check("t5_wr_addr_rst", {56'd0, wr_addr16}, 64'd0);
      send_bits(32'hFFFF, 16, 4);
      check("t5_still_idle", {62'd0, state16}, 64'd0);
      check("t5_wr", 64'(wr16_cnt - w0), 64'd0);
      check("t5_err", 64'(err16_cnt - e0), 64'd0);
      csn = 1'b1;
      tick(8);
      w0 = wr16_cnt;
      exp16_q.push_back({8'h20, 32'hA5A5});
      csn_start();
      send_bits(32'h20, 8, 4);
      send_bits(32'hA5A5, 16, 4);
      csn_end();
      check("t5_good_wr", 64'(wr16_cnt - w0), 64'd1);

      // 6: minimum timing, 32-bit words, csn rise aligned with a final bit
      sel32 = 1'b1;
      tick(8);
      w0 = wr32_cnt; e0 = err32_cnt;
      exp32_q.push_back({8'h3C, 32'hDEADBEEF});
      csn_start();
      send_bits(32'h3C, 8, 3);
      send_bits(32'hDEADBEEF, 32, 3);
      csn_end();
      check("t6_wr", 64'(wr32_cnt - w0), 64'd1);
      check("t6_err", 64'(err32_cnt - e0), 64'd0);
      w0 = wr32_cnt; e0 = err32_cnt;
      csn_start();
      send_bits(32'h3D, 8, 3);
      send_bits(32'h7FFFFFFF, 31, 3);
      sdata = 1'b1;
      tick(3);
      sclk = 1'b1;
      csn = 1'b1;
      tick(3);
      sclk = 1'b0;
      tick(8);
      check("t6_align_wr", 64'(wr32_cnt - w0), 64'd0);
      check("t6_align_err", 64'(err32_cnt - e0), 64'd1);
      check("t6_busy32", {63'd0, busy32}, 64'd0);
      sel32 = 1'b0;
      tick(4);

      check("q16_drained", 64'(exp16_q.size()), 64'd0);
      check("q32_drained", 64'(exp32_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not complete within time limit");
      $fatal(1);
   end

endmodule
